// File: rtl/dispatch_pkg.sv
// Shared types for the task dispatcher: FSM state encodings and the core id type.
package dispatch_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_LAUNCH  = 3'd3;
  localparam logic [2:0] ST_BACKOFF = 3'd4;

  typedef enum logic [2:0] {
    DS_IDLE    = 3'd0,
    DS_REQ     = 3'd1,
    DS_WAIT    = 3'd2,
    DS_LAUNCH  = 3'd3,
    DS_BACKOFF = 3'd4
  } dispatch_state_e;

  localparam int CORES_DEFAULT = 4;
  localparam int CIDW_DEFAULT  = $clog2(CORES_DEFAULT);

  typedef logic [CIDW_DEFAULT-1:0] core_id_t;

endpackage

// File: rtl/task_dispatcher_if.sv
// Bundle of task-queue, allocator and core-control signals around the dispatcher.
interface task_dispatcher_if
  import dispatch_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 32
);
  localparam int CIDW = (CORES > 1) ? $clog2(CORES) : 1;

  // Task transfer happens on a rising edge where task_valid && task_ready;
  // task_addr must be stable while task_valid is high and not yet accepted.
  logic                  task_valid;
  logic [ADDR_WIDTH-1:0] task_addr;
  logic                  task_ready;
  logic                  core_request;
  logic                  core_valid;
  logic [CIDW-1:0]       core_id;
  logic                  core_release;
  logic [CIDW-1:0]       released_core_id;
  logic [CORES-1:0]      core_start;
  logic [ADDR_WIDTH-1:0] core_start_addr;
  logic [CORES-1:0]      core_done;
  logic [CORES-1:0]      busy_mask;
  logic                  err;
  dispatch_state_e       dbg_state;

  modport master (
    input  task_valid, task_addr, core_valid, core_id, core_done,
    output task_ready, core_request, core_release, released_core_id,
           core_start, core_start_addr, busy_mask, err, dbg_state
  );

  modport slave (
    output task_valid, task_addr, core_valid, core_id, core_done,
    input  task_ready, core_request, core_release, released_core_id,
           core_start, core_start_addr, busy_mask, err, dbg_state
  );

endinterface

// File: rtl/task_dispatcher_fifo.sv
// Power-of-two FIFO of task start addresses; head is the oldest entry.
module task_fifo #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  empty,
  output logic                  full_next,
  output logic [ADDR_WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign full_next = (count_d == (PW+1)'(DEPTH));
  assign head      = mem[rd_ptr_q];

endmodule

// File: rtl/task_dispatcher.sv
// Pulls queued tasks, obtains a core from the allocator, launches it, and hands
// cores back to the allocator as they report completion.
module task_dispatcher
  import dispatch_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int RETRY_GAP  = 8
) (
  input logic               clk,
  input logic               reset,
  task_dispatcher_if.master bus
);
  localparam int CIDW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int CW   = $clog2(RETRY_GAP + 1);
  // REQ and WAIT already account for two of the RETRY_GAP+2 cycles between requests.
  localparam logic [CW-1:0] BACKOFF_LOAD = CW'((RETRY_GAP > 2) ? RETRY_GAP - 2 : 0);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CORES-1:0]      pending_q, pending_d;
  logic [CORES-1:0]      busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  ready_q, req_q, rel_q;
  logic [CIDW-1:0]       rel_id_q;
  logic [CORES-1:0]      start_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty, fifo_full_next;
  logic [ADDR_WIDTH-1:0] fifo_head;

  logic [CORES-1:0]      merged, rel_onehot, grant_set;
  logic [CIDW-1:0]       rel_idx;
  logic                  rel_fire, spurious, bad_grant;

  assign push = bus.task_valid & ready_q & ~fifo_full;

  task_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (bus.task_addr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next),
    .head      (fifo_head)
  );

  // Completions are only honoured for cores that are running or already pending.
  always_comb begin
    merged     = pending_q | (bus.core_done & (busy_q | pending_q));
    rel_fire   = |merged;
    rel_onehot = merged & (~merged + 1'b1);
    rel_idx    = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (merged[i]) rel_idx = CIDW'(i);
    end
    // A done on the bit being released right now counts as a fresh completion.
    pending_d  = (merged & ~rel_onehot) | (bus.core_done & pending_q & rel_onehot);
    spurious   = |(bus.core_done & ~busy_q & ~pending_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_set = '0;
    bad_grant = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !rel_fire) state_d = ST_REQ;
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.core_valid && !busy_q[bus.core_id]) begin
          grant_set = CORES'(1) << bus.core_id;
          state_d   = ST_LAUNCH;
        end else begin
          bad_grant = bus.core_valid;
          cnt_d     = BACKOFF_LOAD;
          state_d   = ST_BACKOFF;
        end
      end
      ST_LAUNCH: begin
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      ST_BACKOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (busy_q & ~rel_onehot) | grant_set;
    err_d  = err_q | spurious | bad_grant | (|(pending_q & ~busy_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pending_q    <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      req_q        <= 1'b0;
      rel_q        <= 1'b0;
      rel_id_q     <= '0;
      start_q      <= '0;
      start_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ready_q   <= ~fifo_full_next;
      req_q     <= (state_d == ST_REQ);
      rel_q     <= rel_fire;
      rel_id_q  <= rel_idx;
      start_q   <= grant_set;
      if (grant_set != '0) start_addr_q <= fifo_head;
    end
  end

  assign bus.task_ready       = ready_q;
  assign bus.core_request     = req_q;
  assign bus.core_release     = rel_q;
  assign bus.released_core_id = rel_id_q;
  assign bus.core_start       = start_q;
  assign bus.core_start_addr  = start_addr_q;
  assign bus.busy_mask        = busy_q;
  assign bus.err              = err_q;
  assign bus.dbg_state        = dispatch_state_e'(state_q);

endmodule

// File: tb/tb_task_dispatcher.sv
// Scenario bench for task_dispatcher with an allocator model and launch/release scoreboards.
module tb_task_dispatcher;
  import dispatch_pkg::*;

  localparam int CORES     = 4;
  localparam int AW        = 32;
  localparam int DEPTH     = 4;
  localparam int RETRY_GAP = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  task_dispatcher_if #(.CORES(CORES), .ADDR_WIDTH(AW)) bus ();

  task_dispatcher #(
    .CORES      (CORES),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RETRY_GAP  (RETRY_GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [CORES+AW-1:0] exp_q[$];
  core_id_t            exp_rel_q[$];
  logic [CIDW_DEFAULT:0] grant_q[$];
  int                  req_log[$];
  int                  start_log[$];
  int                  rel_count = 0;
  logic                req_prev = 1'b0;

  // Allocator model and output monitor, evaluated on every falling edge.
  initial begin
    logic [CIDW_DEFAULT:0] g;
    logic [CORES+AW-1:0]   e;
    core_id_t              er;
    bus.core_valid = 1'b0;
    bus.core_id    = '0;
    forever begin
      @(negedge clk);
      bus.core_valid = 1'b0;
      if (!reset) req_prev = 1'b0;
      else if (req_prev && grant_q.size() > 0) begin
        g = grant_q.pop_front();
        bus.core_valid = g[CIDW_DEFAULT];
        bus.core_id    = g[CIDW_DEFAULT-1:0];
      end
      req_prev = bus.core_request;
      if (bus.core_request) req_log.push_back(cyc);
      if (bus.core_start != '0) begin
        start_log.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: got start %b addr %h, required no start", bus.core_start, bus.core_start_addr);
        end else begin
          e = exp_q.pop_front();
          if ({bus.core_start, bus.core_start_addr} !== e) begin
            errors++;
            $display("FAIL start_value: got %b/%h required %b/%h", bus.core_start, bus.core_start_addr, e[CORES+AW-1:AW], e[AW-1:0]);
          end
        end
      end
      if (bus.core_release) begin
        rel_count++;
        checks++;
        if (exp_rel_q.size() == 0) begin
          errors++;
          $display("FAIL release_unexpected: got id %0d, required no release", bus.released_core_id);
        end else begin
          er = exp_rel_q.pop_front();
          if (bus.released_core_id !== er) begin
            errors++;
            $display("FAIL release_id: got %0d required %0d", bus.released_core_id, er);
          end
        end
      end
      if (bus.core_request && bus.core_release) begin
        checks++;
        errors++;
        $display("FAIL req_rel_overlap: got request=1 release=1 required not both at cycle %0d", cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_task(input logic [AW-1:0] a, input int budget, output int acc);
    logic rdy;
    acc = -1;
    bus.task_valid = 1'b1;
    bus.task_addr  = a;
    for (int i = 0; i < budget; i++) begin
      rdy = bus.task_ready;
      step();
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    bus.task_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget && start_log.size() < n; i++) step();
    checks++;
    if (start_log.size() < n) begin
      errors++;
      $display("FAIL start_timeout: got %0d starts required %0d", start_log.size(), n);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    step();
    step();
    checks++;
    if ({bus.task_ready, bus.core_request, bus.core_release, bus.released_core_id, bus.core_start,
         bus.core_start_addr, bus.busy_mask, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b req=%b rel=%b start=%b busy=%b err=%b required all 0",
               bus.task_ready, bus.core_request, bus.core_release, bus.core_start, bus.busy_mask, bus.err);
    end
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.task_ready !== 1'b1 || bus.dbg_state !== DS_IDLE) begin
      errors++;
      $display("FAIL reset_release: got ready=%b state=%0d required ready=1 state=0", bus.task_ready, bus.dbg_state);
    end
  endtask

  task automatic release_one(input logic [CORES-1:0] done, input core_id_t id);
    exp_rel_q.push_back(id);
    bus.core_done = done;
    step();
    bus.core_done = '0;
    checks++;
    if (bus.core_release !== 1'b1 || bus.released_core_id !== id) begin
      errors++;
      $display("FAIL release_latency: got rel=%b id=%0d required rel=1 id=%0d", bus.core_release, bus.released_core_id, id);
    end
  endtask

  task automatic test_single();
    int acc, r0, n0;
    r0 = req_log.size();
    n0 = start_log.size();
    grant_q.push_back({1'b1, 2'd2});
    exp_q.push_back({4'b0100, 32'h0000_1000});
    push_task(32'h0000_1000, 5, acc);
    wait_starts(n0 + 1, 10);
    checks++;
    if (req_log.size() - r0 !== 1 || req_log.size() <= r0 || req_log[r0] !== acc + 1) begin
      errors++;
      $display("FAIL single_request: got %0d requests required 1 at cycle %0d", req_log.size() - r0, acc + 1);
    end
    checks++;
    if (start_log.size() <= n0 || start_log[n0] !== acc + 3) begin
      errors++;
      $display("FAIL single_latency: got start cycle %0d required %0d", (start_log.size() > n0) ? start_log[n0] : -1, acc + 3);
    end
    checks++;
    if (bus.busy_mask !== 4'b0100) begin
      errors++;
      $display("FAIL single_busy: got %b required 0100", bus.busy_mask);
    end
    release_one(4'b0100, 2'd2);
    step();
    checks++;
    if (bus.busy_mask !== 4'b0000) begin
      errors++;
      $display("FAIL single_busy_clear: got %b required 0000", bus.busy_mask);
    end
  endtask

  task automatic test_refusal();
    int acc, r0, n0;
    r0 = req_log.size();
    n0 = start_log.size();
    grant_q.push_back({1'b0, 2'd0});
    grant_q.push_back({1'b0, 2'd0});
    grant_q.push_back({1'b1, 2'd0});
    exp_q.push_back({4'b0001, 32'h0000_2000});
    push_task(32'h0000_2000, 5, acc);
    wait_starts(n0 + 1, 60);
    checks++;
    if (req_log.size() - r0 !== 3) begin
      errors++;
      $display("FAIL refusal_count: got %0d requests required 3", req_log.size() - r0);
    end else begin
      checks++;
      if (req_log[r0+1] - req_log[r0] !== RETRY_GAP + 2 || req_log[r0+2] - req_log[r0+1] !== RETRY_GAP + 2) begin
        errors++;
        $display("FAIL refusal_spacing: got %0d,%0d required %0d", req_log[r0+1] - req_log[r0],
                 req_log[r0+2] - req_log[r0+1], RETRY_GAP + 2);
      end
      checks++;
      if (start_log.size() <= n0 || start_log[n0] !== req_log[r0+2] + 2) begin
        errors++;
        $display("FAIL refusal_launch: got start cycle %0d required %0d", (start_log.size() > n0) ? start_log[n0] : -1, req_log[r0+2] + 2);
      end
    end
    release_one(4'b0001, 2'd0);
  endtask

  task automatic test_fill();
    int acc, n0;
    logic [AW-1:0] a;
    n0 = start_log.size();
    for (int i = 0; i < DEPTH; i++) begin
      a = 32'h0000_3000 + 32'(i * 16);
      push_task(a, 5, acc);
      checks++;
      if (acc < 0) begin
        errors++;
        $display("FAIL fill_accept: got refused task %0d required accepted", i);
      end
    end
    checks++;
    if (bus.task_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: got %b required 0", bus.task_ready);
    end
    push_task(32'h0000_3040, 5, acc);
    checks++;
    if (acc !== -1) begin
      errors++;
      $display("FAIL fill_overflow: got accept at %0d required held", acc);
    end
    for (int i = 0; i < CORES; i++) begin
      logic [CORES-1:0] oh;
      oh = CORES'(1) << i;
      grant_q.push_back({1'b1, 2'(i)});
      exp_q.push_back({oh, 32'h0000_3000 + 32'(i * 16)});
    end
    push_task(32'h0000_3040, 100, acc);
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL fill_fifth: got refused required accepted after pop");
    end
    wait_starts(n0 + 4, 200);
    checks++;
    if (bus.busy_mask !== 4'b1111) begin
      errors++;
      $display("FAIL fill_busy: got %b required 1111", bus.busy_mask);
    end
    release_one(4'b0001, 2'd0);
    grant_q.push_back({1'b1, 2'd0});
    exp_q.push_back({4'b0001, 32'h0000_3040});
    wait_starts(n0 + 5, 60);
    step();
    checks++;
    if (bus.busy_mask !== 4'b1111 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL fill_relaunch: got busy=%b err=%b required 1111/0", bus.busy_mask, bus.err);
    end
  endtask

  task automatic test_multi_release();
    exp_rel_q.push_back(2'd1);
    exp_rel_q.push_back(2'd3);
    bus.core_done = 4'b1010;
    step();
    bus.core_done = '0;
    checks++;
    if (bus.core_release !== 1'b1 || bus.released_core_id !== 2'd1 || bus.core_request !== 1'b0) begin
      errors++;
      $display("FAIL multi_first: got rel=%b id=%0d req=%b required 1/1/0", bus.core_release, bus.released_core_id, bus.core_request);
    end
    step();
    checks++;
    if (bus.core_release !== 1'b1 || bus.released_core_id !== 2'd3 || bus.core_request !== 1'b0) begin
      errors++;
      $display("FAIL multi_second: got rel=%b id=%0d req=%b required 1/3/0", bus.core_release, bus.released_core_id, bus.core_request);
    end
    step();
    checks++;
    if (bus.core_release !== 1'b0 || bus.busy_mask !== 4'b0101) begin
      errors++;
      $display("FAIL multi_after: got rel=%b busy=%b required 0/0101", bus.core_release, bus.busy_mask);
    end
    exp_rel_q.push_back(2'd0);
    exp_rel_q.push_back(2'd2);
    bus.core_done = 4'b0101;
    step();
    bus.core_done = '0;
    step();
    step();
    checks++;
    if (bus.busy_mask !== 4'b0000 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL multi_clear: got busy=%b err=%b required 0000/0", bus.busy_mask, bus.err);
    end
  endtask

  task automatic test_spurious();
    int r;
    r = rel_count;
    bus.core_done = 4'b1000;
    step();
    bus.core_done = '0;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_err: got %b required 1", bus.err);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (rel_count !== r || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_hold: got releases=%0d err=%b required 0 releases err=1", rel_count - r, bus.err);
    end
  endtask

  task automatic test_reset_mid();
    int acc, n0, r0, k;
    push_task(32'h0000_4000, 5, acc);
    push_task(32'h0000_4010, 5, acc);
    k = 0;
    while (bus.dbg_state !== DS_WAIT && k < 30) begin
      step();
      k++;
    end
    checks++;
    if (bus.dbg_state !== DS_WAIT) begin
      errors++;
      $display("FAIL reset_mid_wait: got state %0d required %0d", bus.dbg_state, DS_WAIT);
    end
    n0 = start_log.size();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.task_ready, bus.core_request, bus.core_release, bus.core_start, bus.busy_mask, bus.err} !== '0 ||
        bus.dbg_state !== DS_IDLE) begin
      errors++;
      $display("FAIL reset_mid_clear: got ready=%b busy=%b err=%b state=%0d required all 0",
               bus.task_ready, bus.busy_mask, bus.err, bus.dbg_state);
    end
    step();
    step();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.task_ready !== 1'b1 || bus.err !== 1'b0 || bus.busy_mask !== '0) begin
      errors++;
      $display("FAIL reset_mid_release: got ready=%b err=%b busy=%b required 1/0/0000", bus.task_ready, bus.err, bus.busy_mask);
    end
    r0 = req_log.size();
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (start_log.size() !== n0 || req_log.size() !== r0) begin
      errors++;
      $display("FAIL reset_mid_idle: got %0d starts %0d requests required 0/0", start_log.size() - n0, req_log.size() - r0);
    end
  endtask

  initial begin
    bus.task_valid = 1'b0;
    bus.task_addr  = '0;
    bus.core_done  = '0;
    test_reset();
    test_single();
    test_refusal();
    test_fill();
    test_multi_release();
    test_spurious();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || exp_rel_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d starts %0d releases outstanding required 0", exp_q.size(), exp_rel_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
